pulse_blinker: RTL and testbench

Converts single-cycle event pulses, such as key-press strobes from the edge detector and auto-repeat logic, into human-visible fixed-length output levels. Each accepted pulse produces exactly one ON window of `ON_CYCLES` followed by a mandatory OFF gap of `OFF_CYCLES`. Pulses that arrive while a blink is in progress are queued in a saturating pending counter and replayed in order, so every press is seen as a distinct blink. The block sits between the input-event logic and LED or buzzer outputs.

---
 rtl/pulse_blinker.sv | 130 +++++++++++++
 tb/tb_pulse_blinker.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/pulse_blinker.sv
// Stretches single-cycle event pulses into ON/OFF blinks, replaying events that arrive mid-blink.
// Define PULSE_BLINKER_QUEUE_EN to queue such events; otherwise they are dropped and flagged on overflow.
module pulse_blinker #(
   parameter int unsigned ON_CYCLES  = 25_000_000,
   parameter int unsigned OFF_CYCLES = 12_500_000,
   parameter int unsigned PEND_MAX   = 7
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          in,
   output logic                          out,
   output logic                          busy,
   output logic [$clog2(PEND_MAX+1)-1:0] pending,
   output logic                          overflow
);

   localparam int unsigned CNT_MAX = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
   localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam int unsigned PEND_W  = $clog2(PEND_MAX+1);

   localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(ON_CYCLES - 1);
   localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(OFF_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ON   = 2'd1,
      S_GAP  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             out_q, out_d;
   logic             ovf_q, ovf_d;
   logic             gap_exit;
   logic             take_now;
   logic             late_evt;

   assign gap_exit = (state_q == S_GAP) && (cnt_q == OFF_LAST);
   // An event landing on the last GAP cycle with nothing queued starts the next blink directly.
   assign take_now = gap_exit && in && (pending == '0);
   assign late_evt = in && (state_q != S_IDLE) && !take_now;

`ifdef PULSE_BLINKER_QUEUE_EN
   logic [PEND_W-1:0] pend_q, pend_d;
   logic              pop, push;

   assign pop  = gap_exit && (pend_q != '0);
   // A full queue still accepts an event when a pop frees a slot on the same cycle.
   assign push = late_evt && ((pend_q != PEND_W'(PEND_MAX)) || pop);

   always_comb begin
      pend_d = pend_q;
      ovf_d  = late_evt && !push;
      if (push && !pop) begin
         pend_d = pend_q + PEND_W'(1);
      end else if (pop && !push) begin
         pend_d = pend_q - PEND_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_q <= '0;
      end else begin
         pend_q <= pend_d;
      end
   end

   assign pending = pend_q;
`else
   always_comb begin
      ovf_d = late_evt;
   end

   assign pending = '0;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + CNT_W'(1);
      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (in) begin
               state_d = S_ON;
            end
         end
         S_ON: begin
            if (cnt_q == ON_LAST) begin
               state_d = S_GAP;
               cnt_d   = '0;
            end
         end
         S_GAP: begin
            if (gap_exit) begin
               cnt_d = '0;
               if ((pending != '0) || in) begin
                  state_d = S_ON;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
      out_d = (state_d == S_ON);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         out_q   <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         out_q   <= out_d;
         ovf_q   <= ovf_d;
      end
   end

   assign out      = out_q;
   assign busy     = (state_q != S_IDLE);
   assign overflow = ovf_q;

endmodule

// File: tb/tb_pulse_blinker.sv
// Directed bench for pulse_blinker with ON_CYCLES=4, OFF_CYCLES=2, PEND_MAX=3.
// Expectations follow whichever build PULSE_BLINKER_QUEUE_EN selects.
module tb_pulse_blinker;

   logic       clk;
   logic       rst_n;
   logic       in_s;
   logic       out_s;
   logic       busy_s;
   logic [1:0] pending_s;
   logic       overflow_s;

   int n_chk;
   int n_fail;

   logic [63:0] out_h;
   logic [63:0] busy_h;
   logic [63:0] ovf_h;
   int          pend_h [64];

   pulse_blinker #(
      .ON_CYCLES (4),
      .OFF_CYCLES(2),
      .PEND_MAX  (3)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .in      (in_s),
      .out     (out_s),
      .busy    (busy_s),
      .pending (pending_s),
      .overflow(overflow_s)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] mask(input int lo, input int hi);
      logic [63:0] m;
      m = '0;
      for (int i = lo; i <= hi; i++) m[i] = 1'b1;
      return m;
   endfunction

   function automatic int rises(input logic [63:0] v);
      int r;
      r = 0;
      for (int i = 1; i < 64; i++) if (v[i] && !v[i-1]) r++;
      return r;
   endfunction

   function automatic int pend_max();
      int m;
      m = 0;
      for (int i = 0; i < 64; i++) if (pend_h[i] > m) m = pend_h[i];
      return m;
   endfunction

   // Cycle 0 is the first cycle after reset release; in driven during cycle c is sampled at its end.
   task automatic do_reset();
      in_s  = 1'b0;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      out_h  = '0;
      busy_h = '0;
      ovf_h  = '0;
      for (int i = 0; i < 64; i++) pend_h[i] = 0;
   endtask

   task automatic run(input logic [63:0] pat, input int first, input int n);
      for (int c = first; c < first + n; c++) begin
         in_s = pat[c];
         @(posedge clk);
         #1;
         out_h[c+1]  = out_s;
         busy_h[c+1] = busy_s;
         ovf_h[c+1]  = overflow_s;
         pend_h[c+1] = int'(pending_s);
      end
      in_s = 1'b0;
   endtask

   logic [63:0] pat;

   initial begin
      n_chk  = 0;
      n_fail = 0;
      in_s   = 1'b0;
      rst_n  = 1'b0;
      #23;
      chk("rst_out", 64'(out_s), 64'd0);
      chk("rst_busy", 64'(busy_s), 64'd0);
      chk("rst_pending", 64'(pending_s), 64'd0);
      chk("rst_overflow", 64'(overflow_s), 64'd0);

      // Single event
      do_reset();
      pat = '0; pat[10] = 1'b1;
      run(pat, 0, 30);
      chk("single_out", out_h, mask(11, 14));
      chk("single_busy", busy_h, mask(11, 16));
      chk("single_pend", 64'(pend_max()), 64'd0);

      // Queued events
      do_reset();
      pat = '0; pat[10] = 1'b1; pat[12] = 1'b1; pat[13] = 1'b1;
      run(pat, 0, 40);
`ifdef PULSE_BLINKER_QUEUE_EN
      chk("queue_out", out_h, mask(11, 14) | mask(17, 20) | mask(23, 26));
      chk("queue_pend13", 64'(pend_h[13]), 64'd1);
      chk("queue_pend14", 64'(pend_h[14]), 64'd2);
      chk("queue_pend17", 64'(pend_h[17]), 64'd1);
      chk("queue_pend23", 64'(pend_h[23]), 64'd0);
      chk("queue_ovf", ovf_h, 64'd0);
`else
      chk("queue_out", out_h, mask(11, 14));
      chk("queue_ovf", ovf_h, mask(13, 14));
      chk("queue_pend", 64'(pend_max()), 64'd0);
      chk("queue_busy", busy_h, mask(11, 16));
`endif

      // Held input saturates the queue
      do_reset();
      pat = mask(10, 15);
      run(pat, 0, 45);
`ifdef PULSE_BLINKER_QUEUE_EN
      chk("hold_blinks", 64'(rises(out_h)), 64'd4);
      chk("hold_out", out_h, mask(11, 14) | mask(17, 20) | mask(23, 26) | mask(29, 32));
      chk("hold_ovf", ovf_h, mask(15, 16));
      chk("hold_pend_max", 64'(pend_max()), 64'd3);
`else
      chk("hold_blinks", 64'(rises(out_h)), 64'd1);
      chk("hold_ovf", ovf_h, mask(12, 16));
      chk("hold_pend_max", 64'(pend_max()), 64'd0);
`endif

      // Event on the last GAP cycle with nothing queued
      do_reset();
      pat = '0; pat[10] = 1'b1; pat[16] = 1'b1;
      run(pat, 0, 30);
      chk("gapexit_out", out_h, mask(11, 14) | mask(17, 20));
      chk("gapexit_busy", busy_h, mask(11, 22));
      chk("gapexit_pend", 64'(pend_max()), 64'd0);
      chk("gapexit_ovf", ovf_h, 64'd0);

      // Asynchronous reset in the middle of a blink
      do_reset();
      pat = '0; pat[10] = 1'b1; pat[12] = 1'b1; pat[13] = 1'b1;
      run(pat, 0, 14);
      chk("arst_pre_out", 64'(out_s), 64'd1);
`ifdef PULSE_BLINKER_QUEUE_EN
      chk("arst_pre_pend", 64'(pending_s), 64'd2);
`else
      chk("arst_pre_pend", 64'(pending_s), 64'd0);
`endif
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_out", 64'(out_s), 64'd0);
      chk("arst_busy", 64'(busy_s), 64'd0);
      chk("arst_pend", 64'(pending_s), 64'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      out_h  = '0;
      busy_h = '0;
      run('0, 0, 30);
      chk("arst_after_out", out_h, 64'd0);
      chk("arst_after_busy", busy_h, 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got no completion, expected completion");
      $fatal(1, "timeout");
   end

endmodule
